// File: rtl/spi_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_ctrl_pkg
//  Purpose  : Shared state encoding, default widths and helpers for the
//             SPI frame sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package spi_ctrl_pkg;

  // Default widths used when the sequencer is instantiated without overrides
  localparam int DEF_NCS           = 4;
  localparam int DEF_CHAR_LEN_MAX  = 16;
  localparam int DEF_TRANLEN_WIDTH = 16;
  localparam int DEF_CSDLY_WIDTH   = 4;

  // Frame sequencer state encoding
  localparam logic [2:0] ENC_IDLE     = 3'd0;
  localparam logic [2:0] ENC_CS_SETUP = 3'd1;
  localparam logic [2:0] ENC_LOAD     = 3'd2;
  localparam logic [2:0] ENC_RUN      = 3'd3;
  localparam logic [2:0] ENC_STORE    = 3'd4;
  localparam logic [2:0] ENC_CS_HOLD  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = ENC_IDLE,
    ST_CS_SETUP = ENC_CS_SETUP,
    ST_LOAD     = ENC_LOAD,
    ST_RUN      = ENC_RUN,
    ST_STORE    = ENC_STORE,
    ST_CS_HOLD  = ENC_CS_HOLD
  } xfer_state_e;

  // Width of a chip-select index; a single chip select still needs one bit
  function automatic int cs_idx_width(input int ncs);
    return (ncs > 1) ? $clog2(ncs) : 1;
  endfunction

endpackage : spi_ctrl_pkg
`default_nettype wire

// File: rtl/spi_dly_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : spi_dly_cnt
//  Purpose  : Loadable down-counter with a zero flag, shared by the CS setup
//             and CS hold phases of the frame sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module spi_dly_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Load has priority; decrement saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Counter register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule : spi_dly_cnt
`default_nettype wire

// File: rtl/spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spi_xfer_ctrl
//  Purpose  : Frame-level sequencer for the SPI single-character engine.
//             Accepts a transfer command, asserts the chip select, feeds TX
//             characters from a fall-through FIFO into the engine, pushes the
//             received characters into the RX FIFO, then releases CS and
//             pulses a done flag. All outputs are registered.
//  Revision : 1.0  initial release
// ============================================================================
module spi_xfer_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter  int NCS           = DEF_NCS,
  parameter  int CHAR_LEN_MAX  = DEF_CHAR_LEN_MAX,
  parameter  int TRANLEN_WIDTH = DEF_TRANLEN_WIDTH,
  parameter  int CSDLY_WIDTH   = DEF_CSDLY_WIDTH,
  localparam int CSW           = cs_idx_width(NCS)
) (
  input  logic                     S_SYSCLK,
  input  logic                     S_RESETN,
  input  logic                     S_ENABLE,
  input  logic                     S_CMD_VALID,
  output logic                     S_CMD_READY,
  input  logic [CSW-1:0]           S_CMD_CS,
  input  logic [TRANLEN_WIDTH-1:0] S_CMD_TRANLEN,
  input  logic [CSDLY_WIDTH-1:0]   S_CMD_CSBEF,
  input  logic [CSDLY_WIDTH-1:0]   S_CMD_CSAFT,
  input  logic                     S_TX_EMPTY,
  input  logic [CHAR_LEN_MAX-1:0]  S_TX_DATA,
  output logic                     S_TX_RD,
  input  logic                     S_RX_FULL,
  output logic                     S_RX_WR,
  output logic [CHAR_LEN_MAX-1:0]  S_RX_DATA,
  output logic                     S_CHAR_GO,
  input  logic                     S_CHAR_DONE,
  output logic [CHAR_LEN_MAX-1:0]  S_WCHAR,
  input  logic [CHAR_LEN_MAX-1:0]  S_RCHAR,
  output logic [NCS-1:0]           S_SPI_CS_B,
  output logic                     S_BUSY,
  output logic                     S_XFER_DONE
);

  xfer_state_e              state_q, state_d;
  logic [NCS-1:0]           cs_b_q, cs_b_d;
  logic [TRANLEN_WIDTH-1:0] tranlen_q, tranlen_d;
  logic [TRANLEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [CSDLY_WIDTH-1:0]   csaft_q, csaft_d;
  logic [CHAR_LEN_MAX-1:0]  wchar_q, wchar_d;
  logic [CHAR_LEN_MAX-1:0]  rx_data_q, rx_data_d;
  logic                     go_q, go_d;
  logic                     tx_rd_q, tx_rd_d;
  logic                     rx_wr_q, rx_wr_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;
  logic                     ready_q, ready_d;

  logic                     dly_load;
  logic [CSDLY_WIDTH-1:0]   dly_val;
  logic                     dly_dec;
  logic                     dly_zero;
  logic [NCS-1:0]           cs_dec;
  logic                     cmd_accept;

  // One-hot decode of the command CS index; out-of-range indices select none
  for (genvar gi = 0; gi < NCS; gi++) begin : g_cs_dec
    assign cs_dec[gi] = (S_CMD_CS == CSW'(gi));
  end

  assign cmd_accept = S_ENABLE && S_CMD_VALID && ready_q && (state_q == ST_IDLE);

  // Single delay counter reused for both CS setup and CS hold
  spi_dly_cnt #(
    .WIDTH (CSDLY_WIDTH)
  ) u_dly (
    .clk_i      (S_SYSCLK),
    .rst_ni     (S_RESETN),
    .load_i     (dly_load),
    .load_val_i (dly_val),
    .dec_i      (dly_dec),
    .zero_o     (dly_zero)
  );

  // Next-state and next-output logic; abort via S_ENABLE overrides everything
  always_comb begin
    state_d   = state_q;
    cs_b_d    = cs_b_q;
    tranlen_d = tranlen_q;
    cnt_d     = cnt_q;
    csaft_d   = csaft_q;
    wchar_d   = wchar_q;
    rx_data_d = rx_data_q;
    go_d      = go_q;
    tx_rd_d   = 1'b0;
    rx_wr_d   = 1'b0;
    done_d    = 1'b0;
    dly_load  = 1'b0;
    dly_val   = '0;
    dly_dec   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          tranlen_d = S_CMD_TRANLEN;
          csaft_d   = S_CMD_CSAFT;
          cnt_d     = '0;
          cs_b_d    = ~cs_dec;
          dly_load  = 1'b1;
          dly_val   = S_CMD_CSBEF;
          state_d   = ST_CS_SETUP;
        end
      end

      // The first pop is issued on the edge that enters LOAD so the first
      // TX_RD lands CSBEF+1 cycles after the accept edge.
      ST_CS_SETUP: begin
        if (dly_zero) begin
          state_d = ST_LOAD;
          if (!S_TX_EMPTY) begin
            tx_rd_d = 1'b1;
            wchar_d = S_TX_DATA;
          end
        end else begin
          dly_dec = 1'b1;
        end
      end

      // A high tx_rd_q means the pop is in flight this cycle; start the engine
      ST_LOAD: begin
        if (tx_rd_q) begin
          go_d    = 1'b1;
          state_d = ST_RUN;
        end else if (!S_TX_EMPTY) begin
          tx_rd_d = 1'b1;
          wchar_d = S_TX_DATA;
        end
      end

      ST_RUN: begin
        if (S_CHAR_DONE) begin
          go_d      = 1'b0;
          rx_data_d = S_RCHAR;
          state_d   = ST_STORE;
        end
      end

      // Compare before increment so an all-ones TRANLEN never wraps
      ST_STORE: begin
        if (!S_RX_FULL) begin
          rx_wr_d = 1'b1;
          if (cnt_q == tranlen_q) begin
            dly_load = 1'b1;
            dly_val  = csaft_q;
            state_d  = ST_CS_HOLD;
          end else begin
            cnt_d   = cnt_q + TRANLEN_WIDTH'(1);
            state_d = ST_LOAD;
          end
        end
      end

      ST_CS_HOLD: begin
        if (dly_zero) begin
          cs_b_d  = '1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          dly_dec = 1'b1;
        end
      end

      default: begin
        cs_b_d  = '1;
        go_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    if (!S_ENABLE) begin
      state_d  = ST_IDLE;
      cs_b_d   = '1;
      go_d     = 1'b0;
      tx_rd_d  = 1'b0;
      rx_wr_d  = 1'b0;
      done_d   = 1'b0;
      dly_load = 1'b0;
      dly_dec  = 1'b0;
    end

    busy_d  = (state_d != ST_IDLE);
    ready_d = S_ENABLE && (state_q == ST_IDLE) && (state_d == ST_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge S_SYSCLK) begin
    if (!S_RESETN) begin
      state_q   <= ST_IDLE;
      cs_b_q    <= '1;
      tranlen_q <= '0;
      cnt_q     <= '0;
      csaft_q   <= '0;
      wchar_q   <= '0;
      rx_data_q <= '0;
      go_q      <= 1'b0;
      tx_rd_q   <= 1'b0;
      rx_wr_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cs_b_q    <= cs_b_d;
      tranlen_q <= tranlen_d;
      cnt_q     <= cnt_d;
      csaft_q   <= csaft_d;
      wchar_q   <= wchar_d;
      rx_data_q <= rx_data_d;
      go_q      <= go_d;
      tx_rd_q   <= tx_rd_d;
      rx_wr_q   <= rx_wr_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign S_CMD_READY = ready_q;
  assign S_TX_RD     = tx_rd_q;
  assign S_RX_WR     = rx_wr_q;
  assign S_RX_DATA   = rx_data_q;
  assign S_CHAR_GO   = go_q;
  assign S_WCHAR     = wchar_q;
  assign S_SPI_CS_B  = cs_b_q;
  assign S_BUSY      = busy_q;
  assign S_XFER_DONE = done_q;

endmodule : spi_xfer_ctrl
`default_nettype wire

// File: tb/tb_spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_xfer_ctrl
//  Purpose  : Directed self-checking bench for the SPI frame sequencer with a
//             behavioural loopback character engine and behavioural FIFOs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_xfer_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_cs = '0;
  logic [15:0] cmd_tranlen = '0;
  logic [3:0]  cmd_csbef = '0;
  logic [3:0]  cmd_csaft = '0;
  logic        tx_empty;
  logic [15:0] tx_data;
  logic        tx_rd;
  logic        rx_full = 1'b0;
  logic        rx_wr;
  logic [15:0] rx_data;
  logic        char_go;
  logic        char_done = 1'b0;
  logic [15:0] wchar;
  logic [15:0] rchar = '0;
  logic [3:0]  cs_b;
  logic        busy;
  logic        xfer_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spi_xfer_ctrl #(
    .NCS           (4),
    .CHAR_LEN_MAX  (16),
    .TRANLEN_WIDTH (16),
    .CSDLY_WIDTH   (4)
  ) dut (
    .S_SYSCLK      (clk),
    .S_RESETN      (resetn),
    .S_ENABLE      (enable),
    .S_CMD_VALID   (cmd_valid),
    .S_CMD_READY   (cmd_ready),
    .S_CMD_CS      (cmd_cs),
    .S_CMD_TRANLEN (cmd_tranlen),
    .S_CMD_CSBEF   (cmd_csbef),
    .S_CMD_CSAFT   (cmd_csaft),
    .S_TX_EMPTY    (tx_empty),
    .S_TX_DATA     (tx_data),
    .S_TX_RD       (tx_rd),
    .S_RX_FULL     (rx_full),
    .S_RX_WR       (rx_wr),
    .S_RX_DATA     (rx_data),
    .S_CHAR_GO     (char_go),
    .S_CHAR_DONE   (char_done),
    .S_WCHAR       (wchar),
    .S_RCHAR       (rchar),
    .S_SPI_CS_B    (cs_b),
    .S_BUSY        (busy),
    .S_XFER_DONE   (xfer_done)
  );

  // Behavioural fall-through TX FIFO
  logic [15:0] tx_mem [0:63];
  int          tx_wp = 0;
  int          tx_rp = 0;
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_data  = tx_mem[tx_rp % 64];

  always @(posedge clk) begin
    if (tx_rd && (tx_rp != tx_wp)) tx_rp <= tx_rp + 1;
  end

  // RX FIFO write log
  logic [15:0] rx_log [0:63];
  int          rx_n = 0;

  always @(posedge clk) begin
    if (rx_wr) begin
      rx_log[rx_n % 64] <= rx_data;
      rx_n              <= rx_n + 1;
    end
  end

  // Loopback character engine: DONE four cycles into GO, RCHAR = WCHAR
  logic [2:0] ecnt = '0;
  always @(posedge clk) begin
    if (!char_go) begin
      ecnt      <= '0;
      char_done <= 1'b0;
    end else if (char_done) begin
      char_done <= 1'b0;
    end else if (ecnt == 3'd3) begin
      char_done <= 1'b1;
      rchar     <= wchar;
      ecnt      <= '0;
    end else begin
      ecnt <= ecnt + 3'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_tx(input logic [15:0] d);
    tx_mem[tx_wp % 64] = d;
    tx_wp = tx_wp + 1;
  endtask

  // Present a command and return 1 time unit after the accepting edge
  task automatic send_cmd(input string tag, input logic [1:0] cs, input logic [15:0] tl,
                          input logic [3:0] bef, input logic [3:0] aft);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    cmd_cs = cs; cmd_tranlen = tl; cmd_csbef = bef; cmd_csaft = aft;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check({tag, "_accept"}, {31'd0, ok}, 32'd1);
  endtask

  // Cycle-by-cycle frame observer; k counts edges after the accepting edge
  task automatic watch_frame(input logic [3:0] exp_csb, input int limit,
                             output int first_rd, output int first_go, output int n_wr,
                             output int last_wr, output int done_at, output int glitch);
    first_rd = -1; first_go = -1; n_wr = 0; last_wr = -1; done_at = -1; glitch = 0;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      if (tx_rd && first_rd < 0) first_rd = k;
      if (char_go && first_go < 0) first_go = k;
      if (rx_wr) begin n_wr++; last_wr = k; end
      if (xfer_done) begin
        done_at = k;
        if (cs_b !== 4'hF) glitch++;
        break;
      end
      if (cs_b !== exp_csb) glitch++;
    end
  endtask

  // Count DONE pulses over a quiet window
  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (xfer_done) n++;
    end
  endtask

  int frd, fgo, nwr, lwr, dat, gl, base, nd, bad, rises;
  bit prev_go, seen;

  initial begin
    // ---------------- reset ----------------
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_csb",   {28'd0, cs_b}, 32'hF);
    check("rst_go",    {31'd0, char_go}, 32'd0);
    check("rst_txrd",  {31'd0, tx_rd}, 32'd0);
    check("rst_rxwr",  {31'd0, rx_wr}, 32'd0);
    check("rst_done",  {31'd0, xfer_done}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_wchar", {16'd0, wchar}, 32'd0);
    check("rst_rxd",   {16'd0, rx_data}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    check("rel_ready", {31'd0, cmd_ready}, 32'd1);

    // ---------------- basic frame ----------------
    base = rx_n;
    push_tx(16'h55aa); push_tx(16'h55ab); push_tx(16'h55ac);
    send_cmd("basic", 2'd0, 16'd2, 4'd3, 4'd2);
    check("basic_csb", {28'd0, cs_b}, 32'hE);
    check("basic_busy", {31'd0, busy}, 32'd1);
    watch_frame(4'b1110, 300, frd, fgo, nwr, lwr, dat, gl);
    check("basic_first_rd", frd, 32'd4);
    check("basic_first_go", fgo, 32'd5);
    check("basic_nwr", nwr, 32'd3);
    check("basic_release", dat - lwr, 32'd3);
    check("basic_glitch", gl, 32'd0);
    @(posedge clk); #1;
    check("basic_ready_after", {31'd0, cmd_ready}, 32'd1);
    check("basic_done_once", {31'd0, xfer_done}, 32'd0);
    check("basic_d0", {16'd0, rx_log[base % 64]}, 32'h55aa);
    check("basic_d1", {16'd0, rx_log[(base + 1) % 64]}, 32'h55ab);
    check("basic_d2", {16'd0, rx_log[(base + 2) % 64]}, 32'h55ac);

    // ---------------- TX underrun ----------------
    base = rx_n;
    push_tx(16'h1111);
    send_cmd("under", 2'd0, 16'd2, 4'd0, 4'd0);
    fork
      watch_frame(4'b1110, 400, frd, fgo, nwr, lwr, dat, gl);
      begin
        repeat (200) @(negedge clk);
        check("under_go_low", {31'd0, char_go}, 32'd0);
        check("under_cs_held", {28'd0, cs_b}, 32'hE);
        check("under_busy", {31'd0, busy}, 32'd1);
        push_tx(16'h2222); push_tx(16'h3333);
      end
    join
    check("under_nwr", nwr, 32'd3);
    check("under_glitch", gl, 32'd0);
    check("under_done", {31'd0, dat > 0}, 32'd1);
    check("under_d2", {16'd0, rx_log[(base + 2) % 64]}, 32'h3333);

    // ---------------- RX backpressure ----------------
    base = rx_n;
    rx_full = 1'b1;
    push_tx(16'hA001); push_tx(16'hA002);
    send_cmd("bp", 2'd1, 16'd1, 4'd1, 4'd1);
    fork
      watch_frame(4'b1101, 300, frd, fgo, nwr, lwr, dat, gl);
      begin
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (char_done) begin seen = 1'b1; break; end
        end
        check("bp_char_done_seen", {31'd0, seen}, 32'd1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (rx_wr || tx_rd) bad++;
        end
        check("bp_stall", bad, 32'd0);
        check("bp_hold", {16'd0, rx_data}, 32'hA001);
        rx_full = 1'b0;
      end
    join
    check("bp_nwr", nwr, 32'd2);
    check("bp_glitch", gl, 32'd0);
    check("bp_d0", {16'd0, rx_log[base % 64]}, 32'hA001);
    check("bp_d1", {16'd0, rx_log[(base + 1) % 64]}, 32'hA002);

    // ---------------- abort during RUN of char 2 ----------------
    base = rx_n;
    push_tx(16'hB001); push_tx(16'hB002); push_tx(16'hB003); push_tx(16'hB004);
    send_cmd("abort", 2'd2, 16'd3, 4'd0, 4'd0);
    rises = 0; prev_go = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (char_go && !prev_go) rises++;
      prev_go = char_go;
      if (rises == 2) break;
    end
    check("abort_reached_run2", rises, 32'd2);
    enable = 1'b0;
    @(posedge clk); #1;
    check("abort_csb", {28'd0, cs_b}, 32'hF);
    check("abort_go", {31'd0, char_go}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    count_done(10, nd);
    check("abort_no_done", nd, 32'd0);
    check("abort_rx_count", rx_n - base, 32'd1);
    @(negedge clk); enable = 1'b1;
    base = rx_n;
    send_cmd("reen", 2'd2, 16'd1, 4'd0, 4'd0);
    watch_frame(4'b1011, 200, frd, fgo, nwr, lwr, dat, gl);
    check("reen_nwr", nwr, 32'd2);
    check("reen_glitch", gl, 32'd0);
    check("reen_d0", {16'd0, rx_log[base % 64]}, 32'hB003);
    check("reen_d1", {16'd0, rx_log[(base + 1) % 64]}, 32'hB004);

    // ---------------- zero delays, CS index 3 ----------------
    base = rx_n;
    push_tx(16'hC0DE);
    send_cmd("zero", 2'd3, 16'd0, 4'd0, 4'd0);
    check("zero_csb", {28'd0, cs_b}, 32'h7);
    watch_frame(4'b0111, 100, frd, fgo, nwr, lwr, dat, gl);
    check("zero_first_rd", frd, 32'd1);
    check("zero_nwr", nwr, 32'd1);
    check("zero_release", dat - lwr, 32'd1);
    check("zero_glitch", gl, 32'd0);
    check("zero_d0", {16'd0, rx_log[base % 64]}, 32'hC0DE);

    // ---------------- reset during CS_HOLD ----------------
    push_tx(16'hD00D);
    send_cmd("rmid", 2'd0, 16'd0, 4'd0, 4'd5);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rx_wr) begin seen = 1'b1; break; end
    end
    check("rmid_rxwr_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk); #1;
    check("rmid_csb", {28'd0, cs_b}, 32'hF);
    check("rmid_busy", {31'd0, busy}, 32'd0);
    check("rmid_done", {31'd0, xfer_done}, 32'd0);
    check("rmid_wchar", {16'd0, wchar}, 32'd0);
    check("rmid_rxd", {16'd0, rx_data}, 32'd0);
    check("rmid_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    check("rmid_ready_rel", {31'd0, cmd_ready}, 32'd1);
    count_done(10, nd);
    check("rmid_no_done", nd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the run always terminates
  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_spi_xfer_ctrl
`default_nettype wire
